// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble). One shared add-3 correction
// cell is stepped across the BCD digits one per cycle, followed by a shift per input bit.

module add3_ge5 (
   input  logic [3:0] din,
   output logic [3:0] dout
);
   // Values 13-15 can never occur on a legal schedule; they collapse to 0.
   always_comb begin
      dout = din;
      if (din >= 4'd13)
         dout = 4'd0;
      else if (din >= 4'd5)
         dout = din + 4'd3;
   end
endmodule

// state | meaning
// IDLE  | waiting for iStart; oBcd holds the last result
// ADJ   | correct bcd_r digit d with the shared add3 cell, one digit per cycle
// SHIFT | shift {bcd_r,bin_r} left by one, advance the bit counter
// DONE  | publish bcd_r to oBcd, pulse oDone, return to IDLE
module bin2bcd_seq #(
   parameter int N_BITS   = 16,
   parameter int N_DIGITS = 5
) (
   input  logic                  iClk,
   input  logic                  iReset,
   input  logic                  iStart,
   input  logic [N_BITS-1:0]     iBin,
   output logic [4*N_DIGITS-1:0] oBcd,
   output logic                  oBusy,
   output logic                  oDone
);
   localparam int CW = (N_BITS > 1)   ? $clog2(N_BITS)   : 1;
   localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, ADJ, SHIFT, DONE} state_t;

   state_t                state, state_nxt;
   logic [N_BITS-1:0]     bin_r, bin_nxt;
   logic [4*N_DIGITS-1:0] bcd_r, bcd_nxt;
   logic [4*N_DIGITS-1:0] bcd_out_nxt;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic [DW-1:0]         d, d_nxt;
   logic                  done_nxt;
   logic [3:0]            cell_in, cell_out;

   add3_ge5 u_add3 (
      .din  (cell_in),
      .dout (cell_out)
   );

   always_comb begin
      cell_in = 4'd0;
      for (int i = 0; i < N_DIGITS; i++)
         if (d == DW'(i))
            cell_in = bcd_r[4*i +: 4];
   end

   always_comb begin
      state_nxt   = state;
      bin_nxt     = bin_r;
      bcd_nxt     = bcd_r;
      cnt_nxt     = cnt;
      d_nxt       = d;
      bcd_out_nxt = oBcd;
      done_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (iStart) begin
               bin_nxt   = iBin;
               bcd_nxt   = '0;
               cnt_nxt   = '0;
               d_nxt     = '0;
               state_nxt = ADJ;
            end
         end
         ADJ: begin
            for (int i = 0; i < N_DIGITS; i++)
               if (d == DW'(i))
                  bcd_nxt[4*i +: 4] = cell_out;
            if (d == DW'(N_DIGITS-1)) begin
               d_nxt     = '0;
               state_nxt = SHIFT;
            end else begin
               d_nxt = d + 1'b1;
            end
         end
         SHIFT: begin
            {bcd_nxt, bin_nxt} = {bcd_r[4*N_DIGITS-2:0], bin_r, 1'b0};
            cnt_nxt = cnt + 1'b1;
            if (cnt == CW'(N_BITS-1))
               state_nxt = DONE;
            else
               state_nxt = ADJ;
         end
         DONE: begin
            bcd_out_nxt = bcd_r;
            done_nxt    = 1'b1;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         state <= IDLE;
         bin_r <= '0;
         bcd_r <= '0;
         cnt   <= '0;
         d     <= '0;
         oBcd  <= '0;
         oDone <= 1'b0;
      end else begin
         state <= state_nxt;
         bin_r <= bin_nxt;
         bcd_r <= bcd_nxt;
         cnt   <= cnt_nxt;
         d     <= d_nxt;
         oBcd  <= bcd_out_nxt;
         oDone <= done_nxt;
      end
   end

   assign oBusy = (state != IDLE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed handshake/reset scenarios plus
// random operands compared against a decimal-arithmetic reference.

module tb_bin2bcd_seq;
   localparam int NB  = 16;
   localparam int ND  = 5;
   localparam int LAT = NB*(ND+1)+1;

   logic          iClk = 1'b0;
   logic          iReset;
   logic          iStart;
   logic [NB-1:0] iBin;
   logic [4*ND-1:0] oBcd;
   logic          oBusy;
   logic          oDone;

   int checks   = 0;
   int failures = 0;

   always #5 iClk = ~iClk;

   bin2bcd_seq #(.N_BITS(NB), .N_DIGITS(ND)) dut (
      .iClk   (iClk),
      .iReset (iReset),
      .iStart (iStart),
      .iBin   (iBin),
      .oBcd   (oBcd),
      .oBusy  (oBusy),
      .oDone  (oDone)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [4*ND-1:0] ref_bcd(input int unsigned v);
      logic [4*ND-1:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < ND; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // The correction cell must never see a digit above 12 on a legal schedule.
   always @(negedge iClk)
      if (iReset === 1'b0)
         chk("cell_in_le12", 32'(dut.cell_in > 4'd12), 32'd0);

   // Runs until oDone; optionally holds iStart high or pokes it at given cycles.
   task automatic wait_done(input string tag, input bit hold, input int p1, input int p2,
                            output int lat, output int busy_n);
      logic [4*ND-1:0] bcd0;
      int changes;
      bcd0    = oBcd;
      changes = 0;
      lat     = 0;
      busy_n  = 0;
      while (1) begin
         if (hold)
            iStart = 1'b1;
         else if (lat == p1 || lat == p2) begin
            iStart = 1'b1;
            iBin   = 16'd42;
         end else
            iStart = 1'b0;
         busy_n += int'(oBusy);
         @(posedge iClk); #1;
         lat++;
         if (oDone === 1'b1) break;
         if (oBcd !== bcd0) changes++;
         if (lat >= 400) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            break;
         end
      end
      if (!hold) iStart = 1'b0;
      chk({tag, "_bcd_stable"}, changes, 0);
      chk({tag, "_busy_at_done"}, 32'(oBusy), 0);
   endtask

   task automatic do_conv(input string tag, input logic [NB-1:0] v, input int p1, input int p2);
      int lat, bn;
      @(negedge iClk);
      iStart = 1'b1;
      iBin   = v;
      @(posedge iClk); #1;
      iStart = 1'b0;
      iBin   = NB'($urandom);
      wait_done(tag, 1'b0, p1, p2, lat, bn);
      chk({tag, "_lat"}, lat, LAT);
      chk({tag, "_busy"}, bn, LAT);
      chk({tag, "_bcd"}, 32'(oBcd), 32'(ref_bcd(32'(v))));
      @(posedge iClk); #1;
      chk({tag, "_pulse"}, 32'(oDone), 0);
   endtask

   initial begin
      int lat, bn, n;
      logic [NB-1:0] v;

      assert (10.0**ND > 2.0**NB);

      iReset = 1'b1;
      iStart = 1'b0;
      iBin   = '0;
      repeat (3) @(posedge iClk);
      #1;
      chk("rst_bcd",  32'(oBcd), 0);
      chk("rst_busy", 32'(oBusy), 0);
      chk("rst_done", 32'(oDone), 0);
      @(negedge iClk);
      iReset = 1'b0;

      do_conv("zero", 16'd0, -1, -1);
      do_conv("d1234", 16'd1234, -1, -1);
      do_conv("dmax", 16'd65535, -1, -1);
      do_conv("d9", 16'd9, -1, -1);

      // Re-pulses in the middle and in the DONE cycle are ignored.
      do_conv("ign", 16'd1234, 10, 96);
      n = 0;
      repeat (110) begin
         @(posedge iClk); #1;
         n += int'(oDone);
      end
      chk("ign_no_extra_done", n, 0);
      chk("ign_bcd_hold", 32'(oBcd), 32'h01234);

      // Start held high: one conversion every LAT+1 cycles.
      @(negedge iClk);
      iStart = 1'b1;
      iBin   = 16'd500;
      @(posedge iClk); #1;
      for (int k = 0; k < 3; k++) begin
         wait_done("hold", 1'b1, -1, -1, lat, bn);
         chk("hold_lat", lat, (k == 0) ? LAT : LAT + 1);
         chk("hold_busy", bn, LAT);
         chk("hold_bcd", 32'(oBcd), 32'h00500);
      end
      iStart = 1'b0;
      @(posedge iClk); #1;
      chk("hold_pulse", 32'(oDone), 0);

      // Reset mid-conversion aborts it and clears the result.
      @(negedge iClk);
      iStart = 1'b1;
      iBin   = 16'd1234;
      @(posedge iClk); #1;
      iStart = 1'b0;
      repeat (50) @(posedge iClk);
      #1;
      iReset = 1'b1;
      @(posedge iClk); #1;
      chk("abort_bcd",  32'(oBcd), 0);
      chk("abort_busy", 32'(oBusy), 0);
      chk("abort_done", 32'(oDone), 0);
      iReset = 1'b0;
      n = 0;
      repeat (120) begin
         @(posedge iClk); #1;
         n += int'(oDone);
      end
      chk("abort_no_done", n, 0);
      do_conv("d77", 16'd77, -1, -1);

      do_conv("d9999", 16'd9999, -1, -1);
      do_conv("d10000", 16'd10000, -1, -1);
      for (int i = 0; i < 600; i++) begin
         v = NB'($urandom);
         do_conv("rand", v, -1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
